// File: rtl/layer_arb_pkg.sv
// Shared types and constants for the pixel layer arbiter.
//   IDX_W           width of a palette colour index
//   TRANSPARENT_IDX index meaning "no pixel" (also the background gradient)
//   FLASH_IDX       palette entry shown while a layer is flashing (white)
//   flash_state_t   per-layer hit-flash state
//   frame_cnt_t     8-bit frame/phase counter type
package layer_arb_pkg;

    localparam int IDX_W = 5;
    localparam logic [IDX_W-1:0] TRANSPARENT_IDX = 5'd0;
    localparam logic [IDX_W-1:0] FLASH_IDX       = 5'd1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        ON      = 2'd2,
        OFF     = 2'd3
    } flash_state_t;

    typedef logic [7:0] frame_cnt_t;

    function automatic logic is_opaque(input logic [IDX_W-1:0] idx);
        return idx != TRANSPARENT_IDX;
    endfunction

endpackage

// File: rtl/layer_flash_fsm.sv
// Hit-flash scheduler for one layer. A hit request arms the flash, which
// starts at the next frame boundary and blinks ON/OFF every FLASH_PERIOD
// frames for FLASH_FRAMES frames in total.
// Ports:
//   Clk, Reset   pixel clock, asynchronous active-high reset
//   frame_start  one-cycle pulse at the start of each frame
//   hit_req      one-cycle pulse requesting a flash
//   flash_on     layer's opaque pixels must be replaced by the flash colour
//   busy         flash pending or active
module layer_flash_fsm
    import layer_arb_pkg::*;
#(
    parameter int FLASH_FRAMES = 32,
    parameter int FLASH_PERIOD = 4
) (
    input  logic Clk,
    input  logic Reset,
    input  logic frame_start,
    input  logic hit_req,
    output logic flash_on,
    output logic busy
);

    localparam frame_cnt_t LAST_FRAME = frame_cnt_t'(FLASH_FRAMES - 1);
    localparam frame_cnt_t LAST_PHASE = frame_cnt_t'(FLASH_PERIOD - 1);

    flash_state_t state_r;
    flash_state_t state_nxt_s;
    frame_cnt_t   frm_cnt_r;
    frame_cnt_t   frm_cnt_nxt_s;
    frame_cnt_t   ph_cnt_r;
    frame_cnt_t   ph_cnt_nxt_s;
    logic         flash_on_r;
    logic         busy_r;

    // Next-state and counter logic; a hit during ON/OFF restarts the flash
    // and takes precedence over a coincident frame boundary.
    always_comb begin
        state_nxt_s   = state_r;
        frm_cnt_nxt_s = frm_cnt_r;
        ph_cnt_nxt_s  = ph_cnt_r;
        case (state_r)
            IDLE: begin
                if (hit_req && frame_start) begin
                    state_nxt_s   = ON;
                    frm_cnt_nxt_s = 8'd0;
                    ph_cnt_nxt_s  = 8'd0;
                end else if (hit_req) begin
                    state_nxt_s = PENDING;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            PENDING: begin
                if (frame_start) begin
                    state_nxt_s   = ON;
                    frm_cnt_nxt_s = 8'd0;
                    ph_cnt_nxt_s  = 8'd0;
                end else begin
                    state_nxt_s = PENDING;
                end
            end
            ON, OFF: begin
                if (hit_req) begin
                    state_nxt_s   = ON;
                    frm_cnt_nxt_s = 8'd0;
                    ph_cnt_nxt_s  = 8'd0;
                end else if (frame_start) begin
                    if (frm_cnt_r == LAST_FRAME) begin
                        state_nxt_s   = IDLE;
                        frm_cnt_nxt_s = 8'd0;
                        ph_cnt_nxt_s  = 8'd0;
                    end else begin
                        frm_cnt_nxt_s = frm_cnt_r + 8'd1;
                        if (ph_cnt_r == LAST_PHASE) begin
                            ph_cnt_nxt_s = 8'd0;
                            state_nxt_s  = (state_r == ON) ? OFF : ON;
                        end else begin
                            ph_cnt_nxt_s = ph_cnt_r + 8'd1;
                        end
                    end
                end else begin
                    state_nxt_s = state_r;
                end
            end
            default: begin
                state_nxt_s   = IDLE;
                frm_cnt_nxt_s = 8'd0;
                ph_cnt_nxt_s  = 8'd0;
            end
        endcase
    end

    // State, counters and decoded outputs registered together so the
    // outputs change on the same edge as the state.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_r    <= IDLE;
            frm_cnt_r  <= 8'd0;
            ph_cnt_r   <= 8'd0;
            flash_on_r <= 1'b0;
            busy_r     <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            frm_cnt_r  <= frm_cnt_nxt_s;
            ph_cnt_r   <= ph_cnt_nxt_s;
            flash_on_r <= (state_nxt_s == ON);
            busy_r     <= (state_nxt_s != IDLE);
        end
    end

    assign flash_on = flash_on_r;
    assign busy     = busy_r;

endmodule

// File: rtl/pixel_layer_arbiter.sv
// Per-pixel priority arbiter between NUM_LAYERS colour layers sharing one
// palette lookup, with per-layer hit-flash blinking. Latency is 2 cycles.
// Optional build macro LAYER_ARB_COLLIDE_EN adds the per-frame collide
// report (layer 0 overlapping layer j).
// Ports:
//   Clk, Reset   pixel clock, asynchronous active-high reset
//   frame_start  frame boundary pulse (occurs in blanking)
//   pixel_valid  active-video strobe for DrawX/layer_idx
//   DrawX        current column
//   layer_idx    packed indices, layer i at [5i+4:5i], 0 = transparent
//   hit_req      per-layer flash request pulses
//   out_idx      selected palette index
//   out_DrawX    DrawX aligned with out_idx
//   out_valid    pixel_valid aligned with out_idx
//   flash_busy   per-layer flash pending/active
//   collide      (LAYER_ARB_COLLIDE_EN only) previous frame's overlaps
module pixel_layer_arbiter
    import layer_arb_pkg::*;
#(
    parameter int NUM_LAYERS   = 4,
    parameter int FLASH_FRAMES = 32,
    parameter int FLASH_PERIOD = 4
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        frame_start,
    input  logic                        pixel_valid,
    input  logic [9:0]                  DrawX,
    input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
    input  logic [NUM_LAYERS-1:0]       hit_req,
    output logic [IDX_W-1:0]            out_idx,
    output logic [9:0]                  out_DrawX,
    output logic                        out_valid,
    output logic [NUM_LAYERS-1:0]       flash_busy
`ifdef LAYER_ARB_COLLIDE_EN
    ,
    output logic [NUM_LAYERS-2:0]       collide
`endif
);

    logic [9:0]                  s1_drawx_r;
    logic                        s1_valid_r;
    logic [NUM_LAYERS*IDX_W-1:0] s1_idx_r;
    logic [NUM_LAYERS-1:0]       flash_on_s;
    logic [IDX_W-1:0]            lay_s;
    logic [IDX_W-1:0]            pick_s;
    logic                        found_s;
    logic [IDX_W-1:0]            sel_idx_s;

    for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_flash
        layer_flash_fsm #(
            .FLASH_FRAMES(FLASH_FRAMES),
            .FLASH_PERIOD(FLASH_PERIOD)
        ) u_flash (
            .Clk        (Clk),
            .Reset      (Reset),
            .frame_start(frame_start),
            .hit_req    (hit_req[g]),
            .flash_on   (flash_on_s[g]),
            .busy       (flash_busy[g])
        );
    end

    // Stage 1: capture the incoming pixel.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            s1_drawx_r <= 10'd0;
            s1_valid_r <= 1'b0;
            s1_idx_r   <= '0;
        end else begin
            s1_drawx_r <= DrawX;
            s1_valid_r <= pixel_valid;
            s1_idx_r   <= layer_idx;
        end
    end

    // Priority select: lowest-numbered opaque layer wins, flashing layers
    // show the flash colour; blanking forces the background index.
    always_comb begin
        lay_s   = TRANSPARENT_IDX;
        pick_s  = TRANSPARENT_IDX;
        found_s = 1'b0;
        for (int i = 0; i < NUM_LAYERS; i++) begin
            lay_s = s1_idx_r[i*IDX_W +: IDX_W];
            if (!found_s && is_opaque(lay_s)) begin
                found_s = 1'b1;
                pick_s  = flash_on_s[i] ? FLASH_IDX : lay_s;
            end else begin
                found_s = found_s;
            end
        end
        sel_idx_s = s1_valid_r ? pick_s : TRANSPARENT_IDX;
    end

    // Stage 2: registered outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            out_idx   <= TRANSPARENT_IDX;
            out_DrawX <= 10'd0;
            out_valid <= 1'b0;
        end else begin
            out_idx   <= sel_idx_s;
            out_DrawX <= s1_drawx_r;
            out_valid <= s1_valid_r;
        end
    end

`ifdef LAYER_ARB_COLLIDE_EN
    logic [NUM_LAYERS-2:0] sticky_r;
    logic [NUM_LAYERS-2:0] overlap_s;

    // Overlap of layer 0 with each other layer on the current valid pixel.
    always_comb begin
        overlap_s = '0;
        for (int j = 1; j < NUM_LAYERS; j++) begin
            overlap_s[j-1] = s1_valid_r && is_opaque(s1_idx_r[IDX_W-1:0])
                             && is_opaque(s1_idx_r[j*IDX_W +: IDX_W]);
        end
    end

    // Accumulate overlaps over a frame; publish and clear at frame start.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            sticky_r <= '0;
            collide  <= '0;
        end else if (frame_start) begin
            collide  <= sticky_r | overlap_s;
            sticky_r <= '0;
        end else begin
            sticky_r <= sticky_r | overlap_s;
        end
    end
`endif

endmodule
